// File: rtl/jt5205_ctrl_pkg.sv
// Shared types and constants for the jt5205 ADPCM playback sequencer.
// Optional looping playback is enabled with `define JT5205_CTRL_LOOP_EN.
package jt5205_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        HI,
        LO,
        STARVE
    } state_t;

    // Silence codes alternated during starvation so the decoder level stays put
    localparam logic [3:0] SIL_P = 4'h0;
    localparam logic [3:0] SIL_N = 4'h8;

endpackage

// File: rtl/jt5205_ctrl_fetch.sv
// ROM byte fetcher: address counter, ROM handshake and the cur/nxt byte buffers.
// Loop reload is controlled by loop_en, tied low by the top unless JT5205_CTRL_LOOP_EN.
module jt5205_ctrl_fetch #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          flush,
    input  logic          en,
    input  logic          loop_en,
    input  logic          pop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [7:0]    cur,
    output logic          cur_valid,
    output logic          nxt_valid,
    output logic          end_fetched
);

    logic [AW-1:0] start_l;
    logic [AW-1:0] end_l;
    logic [7:0]    nxt;
    logic          req_new;
    logic          capture;
    logic          want;

    // Handshake: rom_cs holds rom_addr steady until a rom_ok seen from the second
    // request cycle on; rom_ok in the first cycle may belong to an older request.
    assign capture = rom_cs && !req_new && rom_ok;
    assign want    = en && !rom_cs && !end_fetched && (!cur_valid || !nxt_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_l     <= '0;
            end_l       <= '0;
            rom_addr    <= '0;
            rom_cs      <= 1'b0;
            req_new     <= 1'b0;
            cur         <= 8'h00;
            nxt         <= 8'h00;
            cur_valid   <= 1'b0;
            nxt_valid   <= 1'b0;
            end_fetched <= 1'b0;
        end else if (flush) begin
            rom_cs      <= 1'b0;
            req_new     <= 1'b0;
            cur_valid   <= 1'b0;
            nxt_valid   <= 1'b0;
            end_fetched <= 1'b0;
        end else if (load) begin
            start_l     <= start_addr;
            end_l       <= end_addr;
            rom_addr    <= start_addr;
            rom_cs      <= 1'b1;
            req_new     <= 1'b1;
            cur_valid   <= 1'b0;
            nxt_valid   <= 1'b0;
            end_fetched <= 1'b0;
        end else begin
            req_new <= 1'b0;
            if (pop) begin
                cur       <= nxt;
                nxt_valid <= 1'b0;
            end
            if (capture) begin
                rom_cs <= 1'b0;
                if (!cur_valid) begin
                    cur       <= rom_data;
                    cur_valid <= 1'b1;
                end else begin
                    nxt       <= rom_data;
                    nxt_valid <= 1'b1;
                end
                if (rom_addr == end_l) begin
                    if (loop_en) rom_addr <= start_l;
                    else         end_fetched <= 1'b1;
                end else begin
                    rom_addr <= rom_addr + AW'(1);
                end
            end else if (want) begin
                rom_cs  <= 1'b1;
                req_new <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/jt5205_ctrl.sv
// ADPCM playback sequencer feeding jt5205 one nibble per irq edge, high nibble first.
// Define JT5205_CTRL_LOOP_EN to add the loop port for seamless repeated playback.
module jt5205_ctrl
    import jt5205_ctrl_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
`ifdef JT5205_CTRL_LOOP_EN
    input  logic          loop,
`endif
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    input  logic          irq,
    output logic [3:0]    din,
    output logic          busy,
    output logic          done,
    output logic          underrun,
    output state_t        state_dbg
);

    state_t     state, state_n;
    logic       irq_l, irq_edge;
    logic       ph, ph_n;
    logic [3:0] din_n;
    logic       done_n, underrun_n;
    logic       load, flush, pop, loop_en;
    logic [7:0] cur;
    logic       cur_valid, nxt_valid, end_fetched;

`ifdef JT5205_CTRL_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    assign irq_edge  = irq & ~irq_l;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    jt5205_ctrl_fetch #(.AW(AW)) u_fetch (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .flush       (flush),
        .en          (busy),
        .loop_en     (loop_en),
        .pop         (pop),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .rom_addr    (rom_addr),
        .rom_cs      (rom_cs),
        .rom_data    (rom_data),
        .rom_ok      (rom_ok),
        .cur         (cur),
        .cur_valid   (cur_valid),
        .nxt_valid   (nxt_valid),
        .end_fetched (end_fetched)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            irq_l    <= 1'b0;
            ph       <= 1'b0;
            din      <= SIL_P;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_n;
            irq_l    <= irq;
            ph       <= ph_n;
            din      <= din_n;
            done     <= done_n;
            underrun <= underrun_n;
        end
    end

    always_comb begin
        state_n    = state;
        ph_n       = ph;
        din_n      = din;
        done_n     = 1'b0;
        underrun_n = 1'b0;
        load       = 1'b0;
        flush      = 1'b0;
        pop        = 1'b0;
        if (stop) begin
            state_n = IDLE;
            din_n   = SIL_P;
            flush   = 1'b1;
        end else if (start) begin
            state_n = PRIME;
            load    = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                PRIME: if (cur_valid) state_n = HI;
                HI: begin
                    if (irq_edge) begin
                        din_n   = cur[7:4];
                        state_n = LO;
                    end
                end
                LO: begin
                    if (irq_edge) begin
                        din_n = cur[3:0];
                        if (nxt_valid) begin
                            pop     = 1'b1;
                            state_n = HI;
                        end else if (end_fetched) begin
                            done_n  = 1'b1;
                            flush   = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ph_n    = 1'b0;
                            state_n = STARVE;
                        end
                    end
                end
                STARVE: begin
                    // A late byte may arrive on the same cycle as a due code;
                    // that slot still gets silence and the byte plays next.
                    if (irq_edge) begin
                        din_n      = ph ? SIL_P : SIL_N;
                        ph_n       = ~ph;
                        underrun_n = 1'b1;
                    end
                    if (nxt_valid) begin
                        pop     = 1'b1;
                        state_n = HI;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: doc/jt5205_ctrl.md
# jt5205_ctrl

ADPCM playback sequencer for the jt5205 decoder. It fetches a sample stream byte-by-byte from sound ROM between a latched start and end address, and splits each byte into two 4-bit codes. Each code is presented on the decoder's din at every sample request raised on the decoder's irq. It sits between the sound CPU's register interface and the ROM arbiter on one side, and jt5205 on the other.

## Interface
- AW, 16, ROM byte-address width
- clk  in  1  system clock (same clock as jt5205)
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; latch start_addr/end_addr and begin playback
- stop  in  1  one-cycle pulse; abort playback
- start_addr  in  AW  first byte address
- end_addr  in  AW  last byte address (inclusive)
- loop  in  1  restart at start_addr after end (present only with JT5205_CTRL_LOOP_EN)
- rom_addr  out  AW  ROM byte address
- rom_cs  out  1  ROM request
- rom_data  in  8  ROM read data
- rom_ok  in  1  ROM data valid
- irq  in  1  jt5205 sample request
- din  out  4  ADPCM code to jt5205
- busy  out  1  playback active
- done  out  1  one-cycle pulse when the last code has been issued
- underrun  out  1  one-cycle pulse when a code was due and no data was ready

## Operation
- Reset values: rom_addr=0, rom_cs=0, din=4'h0, busy=0, done=0, underrun=0, state IDLE, buffers invalid.
- Buffers: cur (byte being played), nxt (prefetched byte), each with a valid flag.
- Fetcher:
  - Requests while busy, nxt is invalid (or cur is invalid), and the end byte has not yet been fetched.
  - Fills cur first if cur is invalid, otherwise nxt.
  - Address increments modulo 2^AW. If end_addr < start_addr, the address wraps through 0.
  - start_addr==end_addr plays exactly one byte.
- Per byte, the high nibble is issued first, then the low nibble.
- States:
  - IDLE: busy=0. On start, go to PRIME.
  - PRIME: wait for cur valid, then go to HI. irq edges in PRIME are ignored; din is held and no underrun is flagged.
  - HI: on an irq edge, din<=cur[7:4], go to LO.
  - LO: on an irq edge, din<=cur[3:0]. Then:
    - if nxt is valid: cur<=nxt, nxt invalid, go to HI;
    - else if the end byte was consumed: pulse done, go to IDLE;
    - else go to STARVE.
  - STARVE: on each irq edge, din alternates 4'h8, 4'h0 (starting with 4'h8) to hold the decoder level, and underrun pulses. When nxt becomes valid: cur<=nxt, go to HI.
- stop in any state: go to IDLE, din<=4'h0, rom_cs<=0, buffers invalid, no done pulse.
- start in any non-IDLE state: restart from the new addresses and flush both buffers. An outstanding ROM request is dropped.
- start and stop in the same cycle: stop wins.

## Timing
- irq edge detect: irq is registered into irq_l. The edge is irq & ~irq_l, so din updates on the clock edge where irq=1 and irq_l=0, one cycle after irq rises.
- ROM handshake:
  - rom_addr is stable while rom_cs=1.
  - rom_data is captured when rom_ok=1, but only from the second cycle of a request at that address onward. A stale rom_ok is ignored.
  - rom_cs drops the cycle after capture.
  - The next request may start the following cycle.
- start to first rom_cs: 1 cycle.
- done is asserted in the same cycle din takes the final low nibble.
- busy falls together with done.

## Configuration
- JT5205_CTRL_LOOP_EN defined:
  - The loop port exists.
  - If loop=1 when the end byte is fetched, the fetcher reloads the latched start address and playback continues seamlessly.
  - done is not pulsed; loop is sampled at each end-byte fetch.
- Undefined: no loop port, and playback is always one-shot.

## Structure
- Package jt5205_ctrl_pkg holds:
  - the state enum (IDLE, PRIME, HI, LO, STARVE);
  - constants SIL_P=4'h0 and SIL_N=4'h8.
- Sub-module jt5205_ctrl_fetch: address counter, ROM handshake, and the cur/nxt buffer with valid flags. It exposes pop and cur/nxt to the top-level FSM.

## Test plan
- start_addr=0x10, end_addr=0x11, ROM bytes 0xA5, 0x3C, instant rom_ok -> din sequence A,5,3,C on four irq edges; done pulses once with the 4th code; busy=0 afterwards.
- start_addr=end_addr=0x20, byte 0x71 -> din 7 then 1, done with the 2nd code.
- rom_ok delayed 40 cycles, irq every 16 cycles -> din shows 8,0,8… during starvation with an underrun pulse per irq edge, then resumes with the correct nibble.
- stop between the 1st and 2nd nibble -> din=0, busy=0, rom_cs=0 next cycle, no done; a later irq leaves din at 0.
- start_addr=0xFFFF, end_addr=0x0001 (AW=16) -> rom_addr FFFF, 0000, 0001 in order; 6 codes issued, then done.
- LOOP_EN build with loop=1, 2-byte sample -> after 4 codes the sequence repeats with no done pulse; clearing loop ends playback after the current pass.
